// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : CP0 exception/interrupt sequencer: arbitrates, issues, awaits ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl #(
  parameter  int NR_STAGE       = 4,
  parameter  int SYNC_STAGES    = 2,
  parameter  int TIMEOUT        = 8,
  localparam int EXC_CODE_WIDTH = 5,
  localparam int INT_MASK_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [4:0]                         hw_int,
  input  logic [31:0]                        cp0_status,
  input  logic [31:0]                        cp0_cause,
  input  logic [31:0]                        cp0_count,
  input  logic [31:0]                        cp0_compare,
  input  logic                               compare_write,
  input  logic [NR_STAGE-1:0]                req_valid,
  input  logic [NR_STAGE*EXC_CODE_WIDTH-1:0] req_code,
  input  logic [NR_STAGE*32-1:0]             req_epc,
  input  logic [NR_STAGE*32-1:0]             req_badvaddr,
  input  logic                               eret_req,
  input  logic                               int_ok,
  input  logic [31:0]                        int_epc,
  input  logic                               exc_jmp_flag,
  output logic [EXC_CODE_WIDTH-1:0]          exc_code,
  output logic [31:0]                        exc_epc,
  output logic [31:0]                        exc_badvaddr,
  output logic [INT_MASK_WIDTH-1:0]          exc_ip,
  output logic                               add_counter,
  output logic                               flush,
  output logic                               busy,
  output logic                               err_timeout
);

  localparam logic [EXC_CODE_WIDTH-1:0] EC_INT  = 5'h00;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET = 5'h1E;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'h1F;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]                r_state;
  logic [EXC_CODE_WIDTH-1:0] r_code;
  logic [31:0]               r_epc;
  logic [31:0]               r_bad;
  logic [c_CNT_W-1:0]        r_wait_cnt;
  logic                      r_err;
  logic                      r_add;
  logic                      r_timer_pend;
  logic [4:0]                r_sync [SYNC_STAGES];

  logic                      w_int;
  logic                      w_win;
  logic [EXC_CODE_WIDTH-1:0] w_code;
  logic [31:0]               w_epc;
  logic [31:0]               w_bad;
  logic [INT_MASK_WIDTH-1:0] w_ip;
  logic                      w_unused_ok;

  assign w_ip  = {r_timer_pend, r_sync[SYNC_STAGES-1], cp0_cause[9:8]};
  assign w_int = int_ok & cp0_status[0] & ~cp0_status[1] & ~cp0_status[2]
               & (|(w_ip & cp0_status[15:8]));

  // Lowest priority is assigned first so later matches overwrite it.
  always_comb begin
    w_win  = w_int;
    w_code = EC_INT;
    w_epc  = int_epc;
    w_bad  = 32'd0;
    for (int i = 0; i < NR_STAGE - 1; i++) begin
      if (req_valid[i]) begin
        w_win  = 1'b1;
        w_code = req_code[i*EXC_CODE_WIDTH +: EXC_CODE_WIDTH];
        w_epc  = req_epc[i*32 +: 32];
        w_bad  = req_badvaddr[i*32 +: 32];
      end
    end
    if (eret_req) begin
      w_win  = 1'b1;
      w_code = EC_ERET;
      w_epc  = 32'd0;
      w_bad  = 32'd0;
    end
    if (req_valid[NR_STAGE-1]) begin
      w_win  = 1'b1;
      w_code = req_code[(NR_STAGE-1)*EXC_CODE_WIDTH +: EXC_CODE_WIDTH];
      w_epc  = req_epc[(NR_STAGE-1)*32 +: 32];
      w_bad  = req_badvaddr[(NR_STAGE-1)*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_code     <= EC_NONE;
      r_epc      <= 32'd0;
      r_bad      <= 32'd0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_state <= S_ISSUE;
            r_code  <= w_code;
            r_epc   <= w_epc;
            r_bad   <= w_bad;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_code     <= EC_NONE;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (exc_jmp_flag) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == c_CNT_W'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A Compare write acknowledges the timer even if it matches on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer_pend <= 1'b0;
      r_add        <= 1'b0;
    end else begin
      r_add <= ~r_add;
      if (compare_write)
        r_timer_pend <= 1'b0;
      else if (cp0_count == cp0_compare)
        r_timer_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 5'd0;
    end else begin
      r_sync[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign exc_code     = r_code;
  assign exc_epc      = r_epc;
  assign exc_badvaddr = r_bad;
  assign exc_ip       = w_ip;
  assign add_counter  = r_add;
  assign flush        = (r_state == S_ISSUE);
  assign busy         = (r_state != S_IDLE);
  assign err_timeout  = r_err;

  assign w_unused_ok = ^{cp0_status[31:16], cp0_status[7:3], cp0_cause[31:10], cp0_cause[7:0]};

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Scoreboard bench for exc_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_ERET = 5'h1E;
  localparam logic [4:0] EC_NONE = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hw_int;
  logic [31:0] cp0_status, cp0_cause, cp0_count, cp0_compare;
  logic        compare_write;
  logic [3:0]  req_valid;
  logic [19:0] req_code;
  logic [127:0] req_epc, req_badvaddr;
  logic        eret_req, int_ok;
  logic [31:0] int_epc;
  logic        exc_jmp_flag;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;
  logic [7:0]  exc_ip;
  logic        add_counter, flush, busy, err_timeout;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_count(cp0_count), .cp0_compare(cp0_compare),
    .compare_write(compare_write), .req_valid(req_valid),
    .req_code(req_code), .req_epc(req_epc), .req_badvaddr(req_badvaddr),
    .eret_req(eret_req), .int_ok(int_ok), .int_epc(int_epc),
    .exc_jmp_flag(exc_jmp_flag), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_ip(exc_ip), .add_counter(add_counter),
    .flush(flush), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [7:0]  ip;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic ack_en   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] c, input logic [31:0] e, input logic [31:0] b,
                          input logic [7:0] ip);
    exp_t x;
    x.code = c; x.epc = e; x.bad = b; x.ip = ip;
    q.push_back(x);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("return_to_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_flush(input int max);
    int n = 0;
    while (!flush && n < max) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", {63'd0, flush}, 64'd1);
  endtask

  // Monitor: each ISSUE cycle consumes one expected entry and optionally acks.
  initial begin
    exc_jmp_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (flush) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_issue: got code %0h epc %0h, none expected", exc_code, exc_epc);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("issue_code", {59'd0, exc_code}, {59'd0, x.code});
          check("issue_epc", {32'd0, exc_epc}, {32'd0, x.epc});
          check("issue_badvaddr", {32'd0, exc_badvaddr}, {32'd0, x.bad});
          check("issue_ip", {56'd0, exc_ip}, {56'd0, x.ip});
          check("issue_busy", {63'd0, busy}, 64'd1);
        end
        exc_jmp_flag = ack_en;
      end else begin
        check("code_none_outside_issue", {59'd0, exc_code}, {59'd0, EC_NONE});
        exc_jmp_flag = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; hw_int = '0; cp0_status = '0; cp0_cause = '0;
    cp0_count = '0; cp0_compare = 32'hFFFF_FFFF; compare_write = 1'b0;
    req_valid = '0; req_code = '0; req_epc = '0; req_badvaddr = '0;
    eret_req = 1'b0; int_ok = 1'b0; int_epc = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_code", {59'd0, exc_code}, {59'd0, EC_NONE});
    check("rst_epc", {32'd0, exc_epc}, 64'd0);
    check("rst_badvaddr", {32'd0, exc_badvaddr}, 64'd0);
    check("rst_ip", {56'd0, exc_ip}, 64'd0);
    check("rst_flags", {60'd0, flush, busy, add_counter, err_timeout}, 64'd0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("add_counter", {63'd0, add_counter}, 64'(k % 2));
    end

    // Stage priority: stage 3 beats stage 1
    req_valid = 4'b1010;
    req_code[1*5 +: 5] = 5'h04; req_epc[1*32 +: 32] = 32'h8000_0100; req_badvaddr[1*32 +: 32] = 32'h11;
    req_code[3*5 +: 5] = 5'h0C; req_epc[3*32 +: 32] = 32'h8000_1000; req_badvaddr[3*32 +: 32] = 32'h33;
    push_exp(5'h0C, 32'h8000_1000, 32'h33, 8'h00);
    @(negedge clk);
    req_valid = '0;
    wait_idle(20);

    // Timer interrupt
    cp0_status = 32'h0000_8001; int_ok = 1'b1; int_epc = 32'h8000_2000;
    cp0_count = 32'h10; cp0_compare = 32'h10;
    push_exp(EC_INT, 32'h8000_2000, 32'h0, 8'h80);
    wait_flush(10);
    cp0_compare = 32'h11; compare_write = 1'b1;
    @(negedge clk);
    compare_write = 1'b0;
    check("timer_pend_cleared", {63'd0, exc_ip[7]}, 64'd0);
    wait_idle(20);
    repeat (5) @(negedge clk);
    check("no_second_int", {63'd0, busy}, 64'd0);
    cp0_count = 32'h11;
    push_exp(EC_INT, 32'h8000_2000, 32'h0, 8'h80);
    wait_flush(10);
    int_ok = 1'b0; cp0_compare = 32'h12; compare_write = 1'b1;
    @(negedge clk);
    compare_write = 1'b0;
    wait_idle(20);

    // Masking by EXL
    cp0_status = 32'h0000_8403; int_ok = 1'b1;
    cp0_count = 32'h20; cp0_compare = 32'h20; hw_int = 5'b00001;
    @(negedge clk);
    check("hw_sync_1edge", {63'd0, exc_ip[2]}, 64'd0);
    @(negedge clk);
    check("hw_sync_2edge", {63'd0, exc_ip[2]}, 64'd1);
    check("masked_timer_pend", {63'd0, exc_ip[7]}, 64'd1);
    repeat (4) @(negedge clk);
    check("masked_no_issue", {63'd0, busy}, 64'd0);
    hw_int = '0; int_ok = 1'b0; cp0_status = '0;
    cp0_compare = 32'h21; compare_write = 1'b1;
    @(negedge clk);
    compare_write = 1'b0;
    repeat (3) @(negedge clk);
    check("ip_cleared", {56'd0, exc_ip}, 64'd0);

    // ERET beats younger stage 0
    eret_req = 1'b1; req_valid = 4'b0001;
    req_code[0 +: 5] = 5'h0A; req_epc[0 +: 32] = 32'h8000_3000; req_badvaddr[0 +: 32] = 32'h44;
    push_exp(EC_ERET, 32'h0, 32'h0, 8'h00);
    @(negedge clk);
    eret_req = 1'b0; req_valid = '0;
    wait_idle(20);
    repeat (4) @(negedge clk);

    // Timeout without acknowledge
    ack_en = 1'b0;
    req_valid = 4'b0100;
    req_code[2*5 +: 5] = 5'h05; req_epc[2*32 +: 32] = 32'h8000_4000; req_badvaddr[2*32 +: 32] = 32'h1234;
    push_exp(5'h05, 32'h8000_4000, 32'h1234, 8'h00);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (busy && cyc < 30) begin
      cyc++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", 64'(cyc), 64'd9);
    check("err_timeout_set", {63'd0, err_timeout}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_timeout_cleared", {63'd0, err_timeout}, 64'd0);

    // Reset during ISSUE
    ack_en = 1'b1;
    req_valid = 4'b0010;
    req_code[1*5 +: 5] = 5'h04; req_epc[1*32 +: 32] = 32'h8000_5000; req_badvaddr[1*32 +: 32] = 32'h0;
    push_exp(5'h04, 32'h8000_5000, 32'h0, 8'h00);
    @(negedge clk);
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    check("rst_issue_code", {59'd0, exc_code}, {59'd0, EC_NONE});
    check("rst_issue_busy", {62'd0, busy, flush}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller that sequences the coprocessor-0 exception inputs. It collects synchronous exception requests from the pipeline stages, ERET, hardware, software and timer interrupts. It picks one winner, drives the CP0 exception-entry port for exactly one cycle, flushes the pipeline, and holds off new requests until CP0 acknowledges with `exc_jmp_flag`. It also generates the CP0 `add_counter` strobe and the timer-interrupt pending bit.

## Interface
- `NR_STAGE`, default 4: number of pipeline stages that can raise exceptions. Index NR_STAGE-1 is the oldest stage (commit).
- `SYNC_STAGES`, default 2: flip-flop depth of the hw_int synchronizer.
- `TIMEOUT`, default 8: maximum number of WAIT cycles before the controller gives up on the acknowledge.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `hw_int` in 5: asynchronous hardware interrupt lines, level-sensitive.
- `cp0_status` in 32: CP0 Status register. Bit 0 is IE, bit 1 is EXL, bit 2 is ERL, bits 15:8 are IM.
- `cp0_cause` in 32: CP0 Cause register. Only bits 9:8 (software interrupts) are used.
- `cp0_count` in 32: CP0 Count register.
- `cp0_compare` in 32: CP0 Compare register.
- `compare_write` in 1: one-cycle pulse when software writes Compare.
- `req_valid` in NR_STAGE: per-stage exception request.
- `req_code` in NR_STAGE*`EXC_CODE_WIDTH`: packed per-stage exception codes.
- `req_epc` in NR_STAGE*32: packed per-stage EPC values.
- `req_badvaddr` in NR_STAGE*32: packed per-stage BadVAddr values.
- `eret_req` in 1: ERET at the commit stage.
- `int_ok` in 1: the commit stage holds a valid instruction that an interrupt can attach to.
- `int_epc` in 32: EPC to record for an interrupt.
- `exc_jmp_flag` in 1: acknowledge from CP0.
- `exc_code` out `EXC_CODE_WIDTH`: to CP0. Equals `EC_NONE` except during ISSUE.
- `exc_epc` out 32: to CP0.
- `exc_badvaddr` out 32: to CP0.
- `exc_ip` out `INT_MASK_WIDTH` (8): to CP0. Value is {timer_pend, hw_sync[4:0], cp0_cause[9:8]}.
- `add_counter` out 1: toggling strobe. Count advances every other cycle.
- `flush` out 1: kills every in-flight instruction.
- `busy` out 1: stalls fetch.
- `err_timeout` out 1: sticky flag, cleared only by rst.

## Operation
- States: IDLE, ISSUE, WAIT.
- **Arbitration in IDLE** (fixed priority, highest first):
  1. req_valid[NR_STAGE-1]
  2. eret_req
  3. req_valid[NR_STAGE-2] down to req_valid[0], where a higher index wins
  4. Interrupt
- **Interrupt condition:** int_ok & IE & ~EXL & ~ERL & |(exc_ip & IM) must all hold.
- **Latching:** the winner's code, EPC and BadVAddr are registered on the accepting edge.
  - ERET latches code `EC_ERET`, EPC 0, BadVAddr 0.
  - An interrupt latches `EC_INT`, int_epc, BadVAddr 0.
- **Transitions:**
  - IDLE → ISSUE when any winner exists.
  - ISSUE → WAIT unconditionally after 1 cycle.
  - WAIT → IDLE when exc_jmp_flag=1.
  - WAIT → IDLE after TIMEOUT cycles in WAIT without exc_jmp_flag. This path also sets err_timeout.
- **Requests outside IDLE:** all requests are ignored in ISSUE and WAIT. They are not queued, because the flush discards their sources.
- **Timer:**
  - timer_pend is set on any edge where cp0_count == cp0_compare.
  - It is cleared on an edge where compare_write=1.
  - If both occur on the same edge, the clear wins.
- **hw_int:** passes through a SYNC_STAGES-deep synchronizer to form hw_sync. There is no latching: it is level-only.
- **add_counter:** toggles every cycle, independent of state.

## Timing
- **Reset values:**
  - state=IDLE.
  - exc_code=`EC_NONE`; exc_epc, exc_badvaddr and exc_ip = 0.
  - flush, busy, add_counter, err_timeout, timer_pend = 0.
  - Synchronizer flops = 0.
- **Reset mid-operation:** rst in ISSUE or WAIT returns the controller to IDLE on that edge. No partial exc_code is emitted after that edge.
- **Output registration:** exc_code, exc_epc and exc_badvaddr are registered.
  - They are valid for exactly the one ISSUE cycle.
  - CP0 samples them at the edge that ends ISSUE.
  - exc_jmp_flag is then high during the first WAIT cycle.
  - A nominal round trip is therefore IDLE → ISSUE → WAIT → IDLE, 3 cycles from the accepting edge.
- **flush:** high during ISSUE only.
- **busy:** high during ISSUE and WAIT.
- **exc_ip:** combinational from registered sources, valid every cycle.
- **hw_int latency:** an hw_int edge reaches exc_ip SYNC_STAGES edges later.
- **After compare_write:** timer_pend reads 0 in the next cycle.

## Test plan
- **Reset:** hold rst for 3 cycles, then release.
  - All outputs take their reset values.
  - exc_code = `EC_NONE`.
  - add_counter reads 0,1,0,1 from the first cycle after release.
- **Stage priority:** req_valid=4'b1010, with stage 1 code 5'h04 and stage 3 code 5'h0C, stage-3 EPC 0x80001000.
  - ISSUE drives code 0x0C and EPC 0x80001000, with flush=1 for exactly one cycle.
  - exc_jmp_flag in WAIT returns the controller to IDLE.
- **Timer interrupt:** count = compare = 0x10, status 0x00008001, int_ok=1, int_epc 0x80002000.
  - The controller issues `EC_INT` with exc_ip 8'h80 and EPC 0x80002000.
  - compare_write then clears timer_pend.
  - With count still equal to the new compare only after it advances, no second interrupt is issued before that match.
- **Masking:** status 0x00008403 (EXL=1) with hw_int[0] high and the timer pending.
  - No ISSUE occurs.
  - exc_ip[2] rises exactly 2 edges after hw_int[0].
- **ERET versus younger stage:** eret_req=1 and req_valid[0]=1 on the same edge.
  - The controller issues `EC_ERET`.
  - The stage-0 request is dropped.
- **Timeout and reset:** no exc_jmp_flag for 8 WAIT cycles.
  - The controller returns to IDLE and err_timeout=1.
  - A following rst clears err_timeout.
  - rst asserted during ISSUE yields IDLE with exc_code `EC_NONE` on the next cycle.
